// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event generator: per-key FSM states,
// millisecond-to-cycle conversion and key index width.
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_e;

  function automatic int unsigned ms_to_cyc(input int unsigned clk_freq,
                                            input int unsigned ms);
    return (clk_freq / 1000) * ms;
  endfunction

  function automatic int unsigned key_idx_w(input int unsigned key_cnt);
    return (key_cnt > 1) ? $clog2(key_cnt) : 1;
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Typematic timer for one key: after a press, ticks once after DELAY_CYC
// cycles and then every RATE_CYC cycles until the key is released.
module key_repeat_fsm
  import key_event_pkg::*;
#(
  parameter int unsigned DELAY_CYC = 30,
  parameter int unsigned RATE_CYC  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic press_i,
  input  logic release_i,
  output logic tick_o
);

  localparam int unsigned MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  // A key released on its terminal count cycle no longer counts as held.
  always_comb begin
    tick_o = 1'b0;
    if (!release_i) begin
      if (state_q == ST_WAIT && cnt_q == CNT_W'(DELAY_CYC - 1))
        tick_o = 1'b1;
      else if (state_q == ST_REPEAT && cnt_q == CNT_W'(RATE_CYC - 1))
        tick_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (press_i) state_q <= ST_WAIT;
        end
        ST_WAIT, ST_REPEAT: begin
          if (release_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (tick_o) begin
            state_q <= ST_REPEAT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Turns debounced active-low key levels into press/auto-repeat events,
// delivered lowest index first over valid/ready. Auto-repeat: KEY_EVENT_REPEAT_EN.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned KEY_CNT         = 8,
  parameter int unsigned REPEAT_DELAY_MS = 300,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  localparam int unsigned IDX_W          = key_idx_w(KEY_CNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_CNT-1:0] keys_stable,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [IDX_W-1:0]   event_key,
  output logic               event_repeat,
  output logic [KEY_CNT-1:0] keys_held
);

  logic [KEY_CNT-1:0] prev_q, held_q, pend_q, pend_d, press;
  logic               vld_q, vld_d, load, grant_found;
  logic [IDX_W-1:0]   key_q, key_d, grant_idx;

`ifdef KEY_EVENT_REPEAT_EN
  localparam int unsigned DELAY_CYC = ms_to_cyc(CLK_FREQ, REPEAT_DELAY_MS);
  localparam int unsigned RATE_CYC  = ms_to_cyc(CLK_FREQ, REPEAT_RATE_MS);

  logic [KEY_CNT-1:0] rel, tick, rep_q, rep_d;
  logic               ev_rep_q, ev_rep_d;

  assign rel = ~prev_q & keys_stable;

  for (genvar i = 0; i < KEY_CNT; i++) begin : g_key
    key_repeat_fsm #(
      .DELAY_CYC (DELAY_CYC),
      .RATE_CYC  (RATE_CYC)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .press_i   (press[i]),
      .release_i (rel[i]),
      .tick_o    (tick[i])
    );
  end

  assign event_repeat = ev_rep_q;
`else
  assign event_repeat = 1'b0;
`endif

  assign press       = prev_q & ~keys_stable;
  assign load        = ~vld_q | event_ready;
  assign event_valid = vld_q;
  assign event_key   = key_q;
  assign keys_held   = held_q;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = KEY_CNT - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

  // Clear the granted flag before merging new requests so an event arriving
  // on the grant cycle is queued rather than coalesced away.
  always_comb begin
    pend_d = pend_q;
`ifdef KEY_EVENT_REPEAT_EN
    rep_d = rep_q;
`endif
    if (load && grant_found) pend_d[grant_idx] = 1'b0;
    for (int i = 0; i < KEY_CNT; i++) begin
`ifdef KEY_EVENT_REPEAT_EN
      if (tick[i] && !pend_d[i]) begin
        pend_d[i] = 1'b1;
        rep_d[i]  = 1'b1;
      end
`endif
      if (press[i]) begin
        pend_d[i] = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
        rep_d[i]  = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    key_d = key_q;
`ifdef KEY_EVENT_REPEAT_EN
    ev_rep_d = ev_rep_q;
`endif
    if (load) begin
      vld_d = grant_found;
      if (grant_found) begin
        key_d = grant_idx;
`ifdef KEY_EVENT_REPEAT_EN
        ev_rep_d = rep_q[grant_idx];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '1;
      held_q <= '0;
      pend_q <= '0;
      vld_q  <= 1'b0;
      key_q  <= '0;
`ifdef KEY_EVENT_REPEAT_EN
      rep_q    <= '0;
      ev_rep_q <= 1'b0;
`endif
    end else begin
      prev_q <= keys_stable;
      held_q <= ~keys_stable;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      key_q  <= key_d;
`ifdef KEY_EVENT_REPEAT_EN
      rep_q    <= rep_d;
      ev_rep_q <= ev_rep_d;
`endif
    end
  end

endmodule
